// File: rtl/aqfp_bench_pkg.sv
// Shared defaults, FSM state and result record for the AQFP vector launcher.
// The result record uses the default core output and tag widths.
package aqfp_bench_pkg;

  localparam int NI_DEF         = 16;
  localparam int NO_DEF         = 5;
  localparam int LATENCY_DEF    = 4;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int SEQ_W_DEF      = 8;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } launcher_state_e;

  typedef struct packed {
    logic [NO_DEF-1:0]    vec;
    logic [SEQ_W_DEF-1:0] seq;
  } result_t;

endpackage

// File: rtl/aqfp_result_fifo.sv
// First-word-fall-through result buffer; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate flag.
module aqfp_result_fifo
  import aqfp_bench_pkg::*;
#(
  parameter int W     = $bits(result_t),
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic [W-1:0] mem_r [DEPTH];
  logic         full_s;

  assign count  = wr_ptr_r - rd_ptr_r;
  assign empty  = (count == {(AW+1){1'b0}});
  assign full_s = (count == DEPTH_C);
  assign rdata  = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer and storage update; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else begin
      if (push && !full_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  aqfp_result_fifo_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .full (full_s)
  );

endmodule

// File: rtl/aqfp_result_fifo_chk.sv
// Checker for the result FIFO: a push must never land on a full buffer.
module aqfp_result_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);

  // Flag any write attempted while the buffer is full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full));
    end
  end

endmodule

// File: rtl/aqfp_vector_launcher.sv
// Drives input vectors into a fixed-latency core, samples its outputs LATENCY
// cycles later and queues tagged results; credits keep the buffer from overflowing.
module aqfp_vector_launcher
  import aqfp_bench_pkg::*;
#(
  parameter int NI         = NI_DEF,
  parameter int NO         = NO_DEF,
  parameter int LATENCY    = LATENCY_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int SEQ_W      = SEQ_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NI-1:0]    in_vec,
  output logic [NI-1:0]    core_x,
  input  logic [NO-1:0]    core_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NO-1:0]    out_vec,
  output logic [SEQ_W-1:0] out_seq,
  input  logic             flush,
  output logic             flush_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]    CREDIT_MAX = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    CREDIT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [SEQ_W-1:0] SEQ_ONE    = {{(SEQ_W-1){1'b0}}, 1'b1};

  launcher_state_e  state_r;
  launcher_state_e  state_next_s;
  logic [CW-1:0]    credit_r;
  logic [CW-1:0]    credit_next_s;
  logic             in_ready_r;
  logic [NI-1:0]    core_x_r;
  logic [SEQ_W-1:0] seq_r;
  logic [LATENCY-1:0] pipe_v_r;
  logic [SEQ_W-1:0] pipe_tag_r [LATENCY];

  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             drained_s;
  logic             fifo_empty_s;
  logic [CW-1:0]    fifo_count_s;
  result_t          push_data_s;
  result_t          head_s;

  assign accept_s    = in_valid & in_ready_r;
  assign push_s      = pipe_v_r[LATENCY-1];
  assign pop_s       = out_valid & out_ready;
  assign drained_s   = (pipe_v_r == {LATENCY{1'b0}}) && (fifo_count_s == {CW{1'b0}});
  assign push_data_s = '{vec: core_y, seq: pipe_tag_r[LATENCY-1]};

  assign in_ready  = in_ready_r;
  assign core_x    = core_x_r;
  assign out_valid = ~fifo_empty_s;
  assign out_vec   = head_s.vec;
  assign out_seq   = head_s.seq;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: flush opens a drain, which closes once nothing is outstanding.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN:     state_next_s = flush ? DRAIN : RUN;
      DRAIN:   state_next_s = drained_s ? RUN : DRAIN;
      default: state_next_s = RUN;
    endcase
  end

  // FSM outputs: drain completion is signalled in the cycle that leaves DRAIN.
  always_comb begin
    flush_done = 1'b0;
    case (state_r)
      RUN:     flush_done = 1'b0;
      DRAIN:   flush_done = drained_s;
      default: flush_done = 1'b0;
    endcase
  end

  // Credit net change: an accept consumes one, a pop returns one; a capture only moves it.
  always_comb begin
    credit_next_s = credit_r;
    case ({accept_s, pop_s})
      2'b10:   credit_next_s = credit_r - CREDIT_ONE;
      2'b01:   credit_next_s = credit_r + CREDIT_ONE;
      default: credit_next_s = credit_r;
    endcase
  end

  // Credit counter and registered admission, so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r   <= CREDIT_MAX;
      in_ready_r <= 1'b0;
    end else begin
      credit_r   <= credit_next_s;
      in_ready_r <= (state_next_s == RUN) && (credit_next_s != {CW{1'b0}});
    end
  end

  // Core drive, sequence tagging and the in-flight delay pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_x_r <= {NI{1'b0}};
      seq_r    <= {SEQ_W{1'b0}};
      pipe_v_r <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        pipe_tag_r[i] <= {SEQ_W{1'b0}};
      end
    end else begin
      pipe_v_r[0]   <= accept_s;
      pipe_tag_r[0] <= seq_r;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v_r[i]   <= pipe_v_r[i-1];
        pipe_tag_r[i] <= pipe_tag_r[i-1];
      end
      if (accept_s) begin
        core_x_r <= in_vec;
        seq_r    <= seq_r + SEQ_ONE;
      end
    end
  end

  aqfp_result_fifo #(
    .W     ($bits(result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (push_data_s),
    .pop   (pop_s),
    .rdata (head_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

endmodule

// File: doc/aqfp_vector_launcher.md
Name: aqfp_vector_launcher

Overview:
- Test-harness stage that feeds a balanced combinational/AQFP benchmark core and collects its results.
- Accepts input vectors over valid/ready, drives them onto the core inputs, and samples the core outputs a fixed LATENCY cycles later.
- Tags each result with a sequence number and buffers it in a FIFO for a valid/ready consumer.
- Credit-based admission guarantees no result is ever dropped.

Parameters:
- NI, 16, core input width (x vector)
- NO, 5, core output width (y vector)
- LATENCY, 4, cycles from core_x update to core_y sample point; legal range 1..16
- FIFO_DEPTH, 8, result buffer entries; power of two; must be >= LATENCY+2 for full throughput
- SEQ_W, 8, sequence tag width

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input vector offered
- in_ready  out  1  vector may be accepted
- in_vec  in  NI  input vector
- core_x  out  NI  registered drive to core inputs x0..x(NI-1)
- core_y  in  NO  core outputs y0..y(NO-1)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_vec  out  NO  sampled core_y
- out_seq  out  SEQ_W  tag of the originating input vector
- flush  in  1  single-cycle drain request
- flush_done  out  1  one-cycle pulse when drain completes

Behaviour:
- Reset state: core_x=0, in_ready=0 during rst and 1 the cycle after, out_valid=0, out_vec=0, out_seq=0, flush_done=0, seq counter=0, in-flight pipe cleared, FIFO empty, state=RUN.
- Accept: in_valid & in_ready at edge E0 → core_x<=in_vec and tag<=seq; seq increments modulo 2^SEQ_W; a valid bit and the tag enter a LATENCY-deep shift pipe.
- core_x holds the last accepted vector when idle; it never returns to 0 except on rst.
- Capture: at edge E0+LATENCY the pipe tail is valid → push {core_y, tag} into the FIFO. out_valid is high from the cycle after that edge (first-word fall-through).
- Output: FIFO head drives out_vec/out_seq; pop on out_valid & out_ready. Order is strictly FIFO, and seq order equals accept order.
- Credits: credit = FIFO_DEPTH − occupancy − inflight, held as a registered counter.
  - in_ready = (state==RUN) & (credit>0).
  - There is no combinational path from out_ready to in_ready; a credit freed by a pop is usable the next cycle.
- Simultaneous accept + capture + pop in one cycle are all legal; occupancy and credit update by their net effect.
- With the credit scheme, overflow is impossible. An assertion fires if a push occurs on a full FIFO.
- FSM:
  - RUN → DRAIN on flush. If flush coincides with an accept, the accept completes and then RUN is left.
  - In DRAIN, in_ready=0.
  - DRAIN → RUN when inflight==0 and the FIFO is empty; flush_done pulses for 1 cycle on that transition.
  - flush in DRAIN is ignored.
  - flush with nothing outstanding gives flush_done on the next cycle.
- rst mid-operation: in-flight results and FIFO contents are discarded with no output handshake; state returns to RUN and seq restarts at 0.
- out_vec/out_seq are undefined-but-stable while out_valid=0; the bench must not check them then.

Decomposition:
- Shared package aqfp_bench_pkg holds:
  - default NI/NO/LATENCY/FIFO_DEPTH/SEQ_W
  - state enum {RUN, DRAIN}
  - result struct {vec, seq}
- One sub-module: aqfp_result_fifo, a synchronous first-word-fall-through FIFO with wrapping pointers plus extra wrap bit, reporting occupancy count.
- The credit counter, delay pipe and FSM stay in the top module.

Test Plan:
All scenarios use a stub core with core_y = core_x[4:0] and default parameters.
- Single vector: in_vec=16'h0013 accepted at E0, out_ready=1 → core_x=16'h0013 after E0; out_valid rises 4 cycles after E0 with out_vec=5'h13, out_seq=0; out_valid low the following cycle.
- Back-pressure: out_ready=0, 10 vectors offered back-to-back → exactly 8 accepted, then in_ready=0. Raising out_ready → seq 0..7 emitted in order, with vecs matching; the remaining 2 are accepted after credits return.
- Throughput: out_ready=1, 20 back-to-back vectors → in_ready never drops after the first; 20 outputs on consecutive cycles, seq 0..19.
- Sequence wrap: 258 vectors streamed → out_seq sequence ...254, 255, 0, 1; vecs intact.
- Flush: 3 vectors accepted, flush pulsed the cycle after the last accept, out_ready=1 → in_ready=0 until done; flush_done is a single pulse the cycle after the 3rd output handshake; in_ready=1 the next cycle. Flush while idle → flush_done one cycle later.
- Reset mid-flight: 2 vectors in pipe plus 1 in FIFO, rst for one cycle → out_valid=0 and core_x=0 after rst; no stale outputs within 10 cycles; the next accepted vector carries out_seq=0.
